// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single memory bus port between
// instruction fetch (IF) and the MEM stage. One transaction is outstanding
// at a time, and MEM wins ties. The block produces sticky per-slot
// completion flags (if_ok_o = fetched_ok, mem_ok_o = access_ok) that stay
// set until the pipeline advances (inst_valid_i).
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   if_*              fetch request (req / dont_fetch / flush / addr) and result (rdata / ok)
//   mem_*             data access (read / write / addr / wdata / wstrb) and result (rdata / ok)
//   inst_valid_i      pipeline advanced this cycle; closes the slot
//   bus_*             bus request side (req / we / addr / wdata / wstrb, gnt)
//                     and response side (rvalid / rdata)
//   busy_o            a transaction is outstanding
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic                if_dont_fetch_i,
  input  logic                if_flush_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ok_o,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ok_o,
  input  logic                inst_valid_i,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                busy_o
);

  typedef enum logic [2:0] {IDLE, REQ_IF, REQ_MEM, WAIT_IF, WAIT_MEM} state_t;

  state_t state, state_nxt;
  logic   mem_pend, if_pend;
  logic   grant_mem, grant_if;
  logic   rsp_if, rsp_mem, rsp_if_keep;
  logic   discard;

  // Sticky ok flags stop a completed access from being reissued within the slot.
  assign mem_pend = (mem_read_i | mem_write_i) & ~mem_ok_o;
  assign if_pend  = if_req_i & ~if_dont_fetch_i & ~if_flush_i & ~if_ok_o;

  assign rsp_if  = (state == WAIT_IF)  & bus_rvalid_i;
  assign rsp_mem = (state == WAIT_MEM) & bus_rvalid_i;
  // A flush that arrives in the same cycle as the response also kills it.
  assign rsp_if_keep = rsp_if & ~discard & ~if_flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    bus_req_o = 1'b0;
    busy_o    = (state != IDLE);
    case (state)
      IDLE: begin
        // No new grant while the slot is closing; the ok flags are about to clear.
        if (!inst_valid_i) begin
          if (mem_pend) begin
            state_nxt = REQ_MEM;
            grant_mem = 1'b1;
          end else if (if_pend) begin
            state_nxt = REQ_IF;
            grant_if  = 1'b1;
          end
        end
      end
      REQ_IF: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_nxt = WAIT_IF;
      end
      REQ_MEM: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_nxt = WAIT_MEM;
      end
      WAIT_IF:  if (bus_rvalid_i) state_nxt = IDLE;
      WAIT_MEM: if (bus_rvalid_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Payload is captured on entry to REQ_x and held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end else if (grant_mem) begin
      bus_we_o    <= mem_write_i;
      bus_addr_o  <= mem_addr_i;
      bus_wdata_o <= mem_wdata_i;
      bus_wstrb_o <= mem_wstrb_i;
    end else if (grant_if) begin
      bus_we_o    <= 1'b0;
      bus_addr_o  <= if_addr_i;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end
  end

  // discard marks an in-flight fetch as obsolete; it is consumed by its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                     discard <= 1'b0;
    else if (rsp_if)                                             discard <= 1'b0;
    else if (if_flush_i && (state == REQ_IF || state == WAIT_IF)) discard <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ok_o    <= 1'b0;
      if_rdata_o <= '0;
    end else begin
      if (inst_valid_i || if_flush_i) if_ok_o <= 1'b0;
      else if (rsp_if_keep)           if_ok_o <= 1'b1;
      if (rsp_if_keep) if_rdata_o <= bus_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ok_o    <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      if (inst_valid_i) mem_ok_o <= 1'b0;
      else if (rsp_mem) mem_ok_o <= 1'b1;
      // Stores leave the load-data register untouched.
      if (rsp_mem && !bus_we_o) mem_rdata_o <= bus_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The stimulus thread pushes expected
// bus requests and expected completion data into queues; a negedge monitor
// pops and compares whenever the DUT presents a request or raises an ok flag.
module tb_mem_port_arbiter;
  logic        clk, rst;
  logic        if_req_i, if_dont_fetch_i, if_flush_i;
  logic [63:0] if_addr_i, if_rdata_o;
  logic        if_ok_o;
  logic        mem_read_i, mem_write_i;
  logic [63:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [7:0]  mem_wstrb_i;
  logic        mem_ok_o, inst_valid_i;
  logic        bus_req_o, bus_we_o;
  logic [63:0] bus_addr_o, bus_wdata_o;
  logic [7:0]  bus_wstrb_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [63:0] bus_rdata_i;
  logic        busy_o;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_dont_fetch_i(if_dont_fetch_i), .if_flush_i(if_flush_i),
    .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ok_o(if_ok_o),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
    .mem_rdata_o(mem_rdata_o), .mem_ok_o(mem_ok_o),
    .inst_valid_i(inst_valid_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .busy_o(busy_o)
  );

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  req_t        exp_req[$];
  logic [63:0] exp_if[$];
  logic [63:0] exp_mem[$];
  int          n_vec = 0;
  int          n_err = 0;

  localparam logic [63:0] MEM_D  = 64'hAAAA_5555_0000_1111;
  localparam logic [63:0] IF_D1  = 64'h0000_0000_0000_0013;
  localparam logic [63:0] IF_D2  = 64'h0000_0097_0000_0017;
  localparam logic [63:0] IF_D3  = 64'h0000_0000_00A0_0093;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic is_mem, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wstrb);
    req_t r;
    r.is_mem = is_mem; r.we = we; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
    exp_req.push_back(r);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!bus_req_o && n < budget) begin
      step();
      n++;
    end
    chk("req_within_budget", bus_req_o, 1);
  endtask

  task automatic grant(input int dly);
    repeat (dly) step();
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
  endtask

  task automatic respond(input int dly, input logic [63:0] data);
    repeat (dly) step();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = data;
    step();
    bus_rvalid_i = 1'b0;
  endtask

  task automatic close_slot();
    inst_valid_i = 1'b1;
    step();
    inst_valid_i = 1'b0;
  endtask

  // Monitor: request payload, no overlapping transactions, completion data.
  logic outstanding = 1'b0, out_mem = 1'b0, prev_if = 1'b0, prev_mem = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 1'b0;
      prev_if     = 1'b0;
      prev_mem    = 1'b0;
    end else begin
      if (bus_req_o) begin
        chk("no_overlap", outstanding, 0);
        chk("req_expected", exp_req.size() > 0, 1);
        if (exp_req.size() > 0) begin
          chk("bus_we",    bus_we_o,    exp_req[0].we);
          chk("bus_addr",  bus_addr_o,  exp_req[0].addr);
          chk("bus_wdata", bus_wdata_o, exp_req[0].wdata);
          chk("bus_wstrb", bus_wstrb_o, exp_req[0].wstrb);
          if (bus_gnt_i) begin
            out_mem     = exp_req[0].is_mem;
            outstanding = 1'b1;
            void'(exp_req.pop_front());
          end
        end
      end
      if (bus_rvalid_i && outstanding) begin
        if (out_mem) chk("no_close_on_mem_rvalid", inst_valid_i, 0);
        outstanding = 1'b0;
      end
      if (if_ok_o && !prev_if) begin
        chk("if_ok_expected", exp_if.size() > 0, 1);
        if (exp_if.size() > 0) chk("if_rdata", if_rdata_o, exp_if.pop_front());
      end
      if (mem_ok_o && !prev_mem) begin
        chk("mem_ok_expected", exp_mem.size() > 0, 1);
        if (exp_mem.size() > 0) chk("mem_rdata", mem_rdata_o, exp_mem.pop_front());
      end
      prev_if  = if_ok_o;
      prev_mem = mem_ok_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", n_err);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {if_req_i, if_dont_fetch_i, if_flush_i, mem_read_i, mem_write_i} = '0;
    {inst_valid_i, bus_gnt_i, bus_rvalid_i} = '0;
    if_addr_i = '0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0; bus_rdata_i = '0;
    step(); step();
    chk("rst_bus_req",   bus_req_o,   0);
    chk("rst_busy",      busy_o,      0);
    chk("rst_if_ok",     if_ok_o,     0);
    chk("rst_mem_ok",    mem_ok_o,    0);
    chk("rst_if_rdata",  if_rdata_o,  0);
    chk("rst_mem_rdata", mem_rdata_o, 0);
    chk("rst_bus_we",    bus_we_o,    0);
    chk("rst_bus_addr",  bus_addr_o,  0);
    chk("rst_bus_wdata", bus_wdata_o, 0);
    chk("rst_bus_wstrb", bus_wstrb_o, 0);
    rst = 1'b0;
    step();

    // Fetch only
    push_req(0, 0, 64'h8000_0000, 0, 0);
    exp_if.push_back(IF_D1);
    if_req_i = 1'b1; if_addr_i = 64'h8000_0000;
    wait_req(5);
    grant(0);
    respond(1, IF_D1);
    chk("fetch_ok", if_ok_o, 1);
    if_req_i = 1'b0;
    close_slot();
    chk("fetch_close_ok", if_ok_o, 0);
    chk("fetch_rdata_kept", if_rdata_o, IF_D1);

    // Contention: MEM read and IF together, MEM goes first
    push_req(1, 0, 64'h8000_1000, 0, 0);
    push_req(0, 0, 64'h8000_0080, 0, 0);
    exp_mem.push_back(MEM_D);
    exp_if.push_back(IF_D2);
    mem_read_i = 1'b1; mem_addr_i = 64'h8000_1000;
    if_req_i = 1'b1;   if_addr_i  = 64'h8000_0080;
    wait_req(5);
    grant(0);
    respond(1, MEM_D);
    chk("cont_mem_ok", mem_ok_o, 1);
    chk("cont_if_not_yet", if_ok_o, 0);
    wait_req(5);
    grant(0);
    respond(0, IF_D2);
    chk("cont_if_ok", if_ok_o, 1);
    chk("cont_mem_ok_sticky", mem_ok_o, 1);
    mem_read_i = 1'b0; if_req_i = 1'b0;
    close_slot();
    chk("cont_close_mem_ok", mem_ok_o, 0);
    chk("cont_close_if_ok", if_ok_o, 0);
    chk("cont_mem_rdata_kept", mem_rdata_o, MEM_D);

    // Store with delayed grant; load data must be untouched
    push_req(1, 1, 64'h8000_2000, 64'hDEAD_BEEF, 8'h0F);
    exp_mem.push_back(MEM_D);
    mem_write_i = 1'b1; mem_addr_i = 64'h8000_2000;
    mem_wdata_i = 64'hDEAD_BEEF; mem_wstrb_i = 8'h0F;
    wait_req(5);
    grant(4);
    respond(2, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("store_ok", mem_ok_o, 1);
    mem_write_i = 1'b0; mem_wdata_i = '0; mem_wstrb_i = '0;
    close_slot();
    chk("store_close_ok", mem_ok_o, 0);

    // Flush while the fetch is in WAIT_IF
    push_req(0, 0, 64'h8000_0100, 0, 0);
    if_req_i = 1'b1; if_addr_i = 64'h8000_0100;
    wait_req(5);
    grant(0);
    push_req(0, 0, 64'h8000_0040, 0, 0);
    exp_if.push_back(IF_D3);
    if_flush_i = 1'b1; if_addr_i = 64'h8000_0040;
    step();
    if_flush_i = 1'b0;
    respond(0, 64'h1234);
    chk("flush_ok_low", if_ok_o, 0);
    chk("flush_rdata_kept", if_rdata_o, IF_D2);
    wait_req(5);
    grant(0);
    respond(1, IF_D3);
    chk("refetch_ok", if_ok_o, 1);
    if_req_i = 1'b0;
    close_slot();

    // Flush in the same cycle as the response
    push_req(0, 0, 64'h8000_0200, 0, 0);
    if_req_i = 1'b1; if_addr_i = 64'h8000_0200;
    wait_req(5);
    grant(0);
    if_flush_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 64'h5555;
    step();
    if_flush_i = 1'b0; bus_rvalid_i = 1'b0; if_req_i = 1'b0;
    chk("flush_same_ok_low", if_ok_o, 0);
    chk("flush_same_rdata_kept", if_rdata_o, IF_D3);
    chk("flush_same_idle", busy_o, 0);

    // Slot-close guard, then async reset while in WAIT_MEM
    push_req(1, 0, 64'h8000_3000, 0, 0);
    mem_read_i = 1'b1; mem_addr_i = 64'h8000_3000; inst_valid_i = 1'b1;
    step();
    chk("guard_no_req", bus_req_o, 0);
    chk("guard_not_busy", busy_o, 0);
    inst_valid_i = 1'b0;
    step();
    chk("guard_req_next", bus_req_o, 1);
    grant(0);
    chk("wait_mem_busy", busy_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_bus_req", bus_req_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_mem_ok", mem_ok_o, 0);
    chk("arst_mem_rdata", mem_rdata_o, 0);
    chk("arst_bus_addr", bus_addr_o, 0);
    mem_read_i = 1'b0;
    step();
    rst = 1'b0;
    respond(0, 64'h7777);
    chk("stray_mem_ok", mem_ok_o, 0);
    chk("stray_busy", busy_o, 0);
    chk("stray_mem_rdata", mem_rdata_o, 0);
    step(); step();
    chk("stray_no_req", bus_req_o, 0);

    step(); step();
    chk("req_queue_drained", exp_req.size(), 0);
    chk("if_queue_drained",  exp_if.size(),  0);
    chk("mem_queue_drained", exp_mem.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
